accel_servo_drive: RTL and testbench



---
 rtl/accel_servo_pkg.sv | 41 ++++
 rtl/servo_pwm_gen.sv | 77 +++++++
 rtl/accel_servo_drive.sv | 169 ++++++++++++++++
 tb/tb_accel_servo_drive.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/accel_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_servo_pkg
// Purpose  : Shared FSM encoding, fixed limits and timing derivations for the
//            accelerometer-to-servo drive.
// Revision : 1.0  initial release
// ============================================================================
package accel_servo_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLAMP  = 3'd1,
    S_FILTER = 3'd2,
    S_SCALE  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  localparam int c_CLAMP_MAX   = 255;
  localparam int c_CLAMP_MIN   = -256;
  localparam int c_SCALE_SHIFT = 9;
  localparam int c_W           = 20;
  localparam int c_N_CH        = 3;

  function automatic int calc_tpu(input int clk_freq);
    return clk_freq / 1_000_000;
  endfunction

  function automatic int calc_period(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  function automatic int calc_center(input int clk_freq, input int min_us, input int max_us);
    return ((min_us + max_us) / 2) * calc_tpu(clk_freq);
  endfunction

  function automatic int calc_span(input int clk_freq, input int min_us, input int max_us);
    return (max_us - min_us) * calc_tpu(clk_freq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen
// Purpose  : Frame counter and N registered comparators; compare values are
//            reloaded from the shadow set only at frame wrap.
// Revision : 1.0  initial release
// ============================================================================
module servo_pwm_gen
  import accel_servo_pkg::*;
#(
  parameter int N_CH   = c_N_CH,
  parameter int W      = c_W,
  parameter int PERIOD = 500_000,
  parameter int CENTER = 37_500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_commit,
  input  logic [N_CH-1:0][W-1:0]   i_shadow,
  output logic [N_CH-1:0]          o_pwm,
  output logic                     o_frame_start
);

  localparam logic [W-1:0] c_LAST     = W'(PERIOD - 1);
  localparam logic [W-1:0] c_CENTER_W = W'(CENTER);

  logic [W-1:0] r_cnt;
  logic         r_pend;
  logic         r_frame_start;
  logic         w_wrap;
  logic         w_load;

  assign w_wrap = (r_cnt == c_LAST);
  // A commit landing on the wrap edge is not yet visible in r_pend, so it waits a frame.
  assign w_load = w_wrap && r_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_wrap ? '0 : r_cnt + W'(1);
      r_frame_start <= w_wrap;
      if (i_commit) begin
        r_pend <= 1'b1;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_frame_start = r_frame_start;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W-1:0] r_cmp;
      logic         r_pwm;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cmp <= c_CENTER_W;
          r_pwm <= 1'b0;
        end else begin
          if (w_load) begin
            r_cmp <= i_shadow[gi];
          end
          r_pwm <= (r_cnt < r_cmp);
        end
      end

      assign o_pwm[gi] = r_pwm;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/accel_servo_drive.sv
`default_nettype none
// ============================================================================
// Module   : accel_servo_drive
// Purpose  : Captures X/Y/Z accelerometer samples, clamps, IIR-filters and
//            scales them to servo pulse widths for three 50 Hz PWM outputs.
// Revision : 1.0  initial release
// ============================================================================
module accel_servo_drive
  import accel_servo_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int PWM_FREQ   = 50,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int FILT_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_data_update,
  input  logic [15:0] i_data_x,
  input  logic [15:0] i_data_y,
  input  logic [15:0] i_data_z,
  input  logic        i_hold,
  output logic [2:0]  o_servo_pwm,
  output logic        o_busy,
  output logic        o_sample_drop,
  output logic        o_frame_start
);

  localparam int c_PERIOD = calc_period(CLK_FREQ, PWM_FREQ);
  localparam int c_CENTER = calc_center(CLK_FREQ, MIN_US, MAX_US);
  localparam int c_SPAN   = calc_span(CLK_FREQ, MIN_US, MAX_US);
  localparam logic [c_W-1:0] c_CENTER_W = c_W'(c_CENTER);

  state_t r_state;
  state_t w_state_next;
  logic [1:0] r_ch;
  logic [1:0] w_ch_next;
  logic w_capture;
  logic w_commit;

  logic signed [15:0] r_smp [0:2];
  logic signed [9:0]  r_s;
  logic signed [10:0] r_f [0:2];
  logic [c_N_CH-1:0][c_W-1:0] r_shadow;
  logic r_drop;

  logic signed [15:0] w_smp_sel;
  logic signed [10:0] w_f_sel;
  logic signed [9:0]  w_clamped;
  logic signed [11:0] w_diff;
  logic signed [11:0] w_step;
  logic signed [10:0] w_f_next;
  logic signed [31:0] w_prod;
  logic [c_W-1:0]     w_width;

  assign w_capture = i_data_update && !i_hold && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ch    <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_state_next = S_CLAMP;
          w_ch_next    = 2'd0;
        end
      end
      S_CLAMP:  w_state_next = S_FILTER;
      S_FILTER: w_state_next = S_SCALE;
      S_SCALE: begin
        if (r_ch < 2'd2) begin
          w_state_next = S_CLAMP;
          w_ch_next    = r_ch + 2'd1;
        end else begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Channel datapath: one sample/filter slot and one multiplier shared by all axes.
  always_comb begin
    w_smp_sel = r_smp[0];
    w_f_sel   = r_f[0];
    if (r_ch == 2'd1) begin
      w_smp_sel = r_smp[1];
      w_f_sel   = r_f[1];
    end else if (r_ch == 2'd2) begin
      w_smp_sel = r_smp[2];
      w_f_sel   = r_f[2];
    end

    if (int'(w_smp_sel) > c_CLAMP_MAX) begin
      w_clamped = 10'(c_CLAMP_MAX);
    end else if (int'(w_smp_sel) < c_CLAMP_MIN) begin
      w_clamped = 10'(c_CLAMP_MIN);
    end else begin
      w_clamped = w_smp_sel[9:0];
    end

    w_diff   = {{2{r_s[9]}}, r_s} - {w_f_sel[10], w_f_sel};
    w_step   = w_diff >>> FILT_SHIFT;
    w_f_next = w_f_sel + 11'(w_step);

    w_prod  = int'(w_f_sel) * c_SPAN;
    w_width = c_W'(c_CENTER + (w_prod >>> c_SCALE_SHIFT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_smp[i] <= '0;
        r_f[i]   <= '0;
      end
      r_s      <= '0;
      r_shadow <= {c_N_CH{c_CENTER_W}};
      r_drop   <= 1'b0;
    end else begin
      r_drop <= i_data_update && (r_state != S_IDLE);
      if (w_capture) begin
        r_smp[0] <= i_data_x;
        r_smp[1] <= i_data_y;
        r_smp[2] <= i_data_z;
      end
      case (r_state)
        S_CLAMP:  r_s           <= w_clamped;
        S_FILTER: r_f[r_ch]     <= w_f_next;
        S_SCALE:  r_shadow[r_ch] <= w_width;
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_sample_drop = r_drop;

  servo_pwm_gen #(
    .N_CH   (c_N_CH),
    .W      (c_W),
    .PERIOD (c_PERIOD),
    .CENTER (c_CENTER)
  ) u_pwm (
    .clk           (clk),
    .rst           (rst),
    .i_commit      (w_commit),
    .i_shadow      (r_shadow),
    .o_pwm         (o_servo_pwm),
    .o_frame_start (o_frame_start)
  );

endmodule
`default_nettype wire

// File: tb/tb_accel_servo_drive.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_servo_drive
// Purpose  : Directed bench; two instances (K=0 and K=2) share stimulus and
//            are run with a 1 MHz / 500 Hz setup (PERIOD 2000, CENTER 1500, SPAN 1000).
// Revision : 1.0  initial release
// ============================================================================
module tb_accel_servo_drive;

  localparam int CLK_FREQ = 1_000_000;
  localparam int PWM_FREQ = 500;
  localparam int PERIOD   = 2000;
  localparam int CENTER   = 1500;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        du   = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] dx   = '0;
  logic [15:0] dy   = '0;
  logic [15:0] dz   = '0;
  logic [2:0]  pwm0, pwm2;
  logic        busy0, busy2, drop0, drop2, fs0, fs2;

  int n_vec = 0;
  int n_err = 0;
  int m_per;
  int m_h0 [3];
  int m_h2 [3];

  always #5 clk = ~clk;

  accel_servo_drive #(
    .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_US(1000), .MAX_US(2000), .FILT_SHIFT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .i_data_update(du), .i_data_x(dx), .i_data_y(dy), .i_data_z(dz),
    .i_hold(hold), .o_servo_pwm(pwm0), .o_busy(busy0), .o_sample_drop(drop0), .o_frame_start(fs0)
  );

  accel_servo_drive #(
    .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_US(1000), .MAX_US(2000), .FILT_SHIFT(2)
  ) dut2 (
    .clk(clk), .rst(rst), .i_data_update(du), .i_data_x(dx), .i_data_y(dy), .i_data_z(dz),
    .i_hold(hold), .o_servo_pwm(pwm2), .o_busy(busy2), .o_sample_drop(drop2), .o_frame_start(fs2)
  );

  task automatic wait_fs();
    int k;
    k = 0;
    while (fs0 !== 1'b1 && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (fs0 !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_fs: frame_start=%b after %0d cycles, required 1", fs0, k);
    end
  endtask

  // Counts high cycles per channel from one frame_start to the next; optionally
  // pulses data_update at cycle inject_at of the frame.
  task automatic measure_frame(input int inject_at, input logic [15:0] ix, iy, iz);
    wait_fs();
    m_per = 0;
    for (int i = 0; i < 3; i++) begin
      m_h0[i] = 0;
      m_h2[i] = 0;
    end
    do begin
      for (int i = 0; i < 3; i++) begin
        m_h0[i] += int'(pwm0[i]);
        m_h2[i] += int'(pwm2[i]);
      end
      if (m_per == inject_at) begin
        dx = ix; dy = iy; dz = iz; du = 1'b1;
      end else begin
        du = 1'b0;
      end
      @(negedge clk);
      m_per++;
    end while (fs0 !== 1'b1 && m_per < 3 * PERIOD);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (pwm0 !== 3'b000) begin n_err++; $display("FAIL reset_pwm0: got %b, required 000", pwm0); end
    n_vec++; if (pwm2 !== 3'b000) begin n_err++; $display("FAIL reset_pwm2: got %b, required 000", pwm2); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    n_vec++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b, required 0", drop0); end
    n_vec++; if (fs0 !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b, required 0", fs0); end
    rst = 1'b0;
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    n_vec++; if (m_per !== PERIOD) begin n_err++; $display("FAIL reset_period: got %0d, required %0d", m_per, PERIOD); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== CENTER) begin n_err++; $display("FAIL reset_w0_%0d: got %0d, required %0d", i, m_h0[i], CENTER); end
      n_vec++; if (m_h2[i] !== CENTER) begin n_err++; $display("FAIL reset_w2_%0d: got %0d, required %0d", i, m_h2[i], CENTER); end
    end
  endtask

  task automatic test_center();
    measure_frame(5, 16'd0, 16'd0, 16'd0);
    for (int f = 0; f < 2; f++) begin
      measure_frame(-1, 16'd0, 16'd0, 16'd0);
      n_vec++; if (m_per !== PERIOD) begin n_err++; $display("FAIL center_period%0d: got %0d, required %0d", f, m_per, PERIOD); end
      n_vec++; if (m_h0[0] !== CENTER) begin n_err++; $display("FAIL center_x%0d: got %0d, required %0d", f, m_h0[0], CENTER); end
    end
  endtask

  task automatic test_clamp();
    int exp_w [3];
    measure_frame(5, 16'sd256, -16'sd300, 16'd0);
    n_vec++; if (m_h0[0] !== CENTER) begin n_err++; $display("FAIL clamp_old_x: got %0d, required %0d", m_h0[0], CENTER); end
    n_vec++; if (m_h0[1] !== CENTER) begin n_err++; $display("FAIL clamp_old_y: got %0d, required %0d", m_h0[1], CENTER); end
    exp_w = '{1998, 1000, 1500};
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== exp_w[i]) begin n_err++; $display("FAIL clamp_w%0d: got %0d, required %0d", i, m_h0[i], exp_w[i]); end
    end
  endtask

  task automatic test_filter();
    measure_frame(5, 16'd0, 16'd0, 16'sd200);
    measure_frame(5, 16'd0, 16'd0, 16'sd200);
    n_vec++; if (m_h2[2] !== 1597) begin n_err++; $display("FAIL filter_first_k2: got %0d, required 1597", m_h2[2]); end
    n_vec++; if (m_h0[2] !== 1890) begin n_err++; $display("FAIL filter_first_k0: got %0d, required 1890", m_h0[2]); end
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    n_vec++; if (m_h2[2] !== 1669) begin n_err++; $display("FAIL filter_second_k2: got %0d, required 1669", m_h2[2]); end
    n_vec++; if (m_h0[2] !== 1890) begin n_err++; $display("FAIL filter_second_k0: got %0d, required 1890", m_h0[2]); end
  endtask

  task automatic test_back_to_back();
    int exp_w [3];
    wait_fs();
    dx = 16'sd100; dy = -16'sd100; dz = 16'd0; du = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      n_vec++; if (busy0 !== (k <= 9)) begin n_err++; $display("FAIL b2b_busy_t%0d: got %b, required %b", k + 1, busy0, (k <= 9)); end
      n_vec++; if (drop0 !== (k == 5)) begin n_err++; $display("FAIL b2b_drop_t%0d: got %b, required %b", k + 1, drop0, (k == 5)); end
      if (k == 4) begin
        dx = -16'sd256; dy = 16'sd255; dz = 16'sd255; du = 1'b1;
      end else begin
        du = 1'b0;
      end
      @(negedge clk);
    end
    exp_w = '{1695, 1304, 1500};
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== exp_w[i]) begin n_err++; $display("FAIL b2b_w%0d: got %0d, required %0d", i, m_h0[i], exp_w[i]); end
    end
  endtask

  task automatic test_mid_frame_and_hold();
    int old_w [3];
    int new_w [3];
    old_w = '{1695, 1304, 1500};
    new_w = '{1000, 1998, 1500};
    measure_frame(89, -16'sd256, 16'sd255, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== old_w[i]) begin n_err++; $display("FAIL midframe_old_w%0d: got %0d, required %0d", i, m_h0[i], old_w[i]); end
    end
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== new_w[i]) begin n_err++; $display("FAIL midframe_new_w%0d: got %0d, required %0d", i, m_h0[i], new_w[i]); end
    end
    hold = 1'b1;
    dx = 16'd0; dy = 16'd0; dz = 16'd0;
    for (int k = 0; k < 40; k++) begin
      du = (k == 3 || k == 20);
      @(negedge clk);
      n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL hold_busy_c%0d: got %b, required 0", k, busy0); end
    end
    du = 1'b0;
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h0[i] !== new_w[i]) begin n_err++; $display("FAIL hold_w%0d: got %0d, required %0d", i, m_h0[i], new_w[i]); end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hi [3];
    int early;
    wait_fs();
    repeat (5) @(negedge clk);
    dx = 16'sd255; dy = 16'sd255; dz = 16'sd255; du = 1'b1;
    @(negedge clk);
    du = 1'b0;
    @(negedge clk);
    n_vec++; if (pwm0 !== 3'b111) begin n_err++; $display("FAIL rstmid_pre_pwm: got %b, required 111", pwm0); end
    n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_busy: got %b, required 1", busy0); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (pwm0 !== 3'b000) begin n_err++; $display("FAIL rstmid_pwm0: got %b, required 000", pwm0); end
    n_vec++; if (pwm2 !== 3'b000) begin n_err++; $display("FAIL rstmid_pwm2: got %b, required 000", pwm2); end
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, required 0", busy0); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    early = 0;
    for (int i = 0; i < 3; i++) hi[i] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      for (int i = 0; i < 3; i++) hi[i] += int'(pwm0[i]);
      if (fs0 === 1'b1) early++;
      @(negedge clk);
    end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL rstmid_early_fs: got %0d pulses, required 0", early); end
    n_vec++; if (fs0 !== 1'b1) begin n_err++; $display("FAIL rstmid_first_fs: got %b, required 1", fs0); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (hi[i] !== CENTER) begin n_err++; $display("FAIL rstmid_first_w%0d: got %0d, required %0d", i, hi[i], CENTER); end
    end
    measure_frame(-1, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (m_h2[i] !== CENTER) begin n_err++; $display("FAIL rstmid_w2_%0d: got %0d, required %0d", i, m_h2[i], CENTER); end
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_clamp();
    test_filter();
    test_back_to_back();
    test_mid_frame_and_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
